// File: rtl/sparse_pack.sv
// Sparse packer: groups N elements, emits a keep-bitmap header beat followed by only the kept values.
// Optional SPARSE_PACK_STAT_EN compiles a saturating pruned-element counter onto prune_cnt.
module sparse_pack #(
  parameter int W = 8,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_prune,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_hdr,
  output logic         out_last,
  output logic [15:0]  prune_cnt
);

  localparam int CW = $clog2(N + 1);
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {FILL, HDR, DATA} state_t;

  state_t        state;
  logic [CW-1:0] pos;
  logic [CW-1:0] kcnt;
  logic [CW-1:0] rd;
  logic [N-1:0]  mask;
  logic          last_flag;
  logic [W-1:0]  buffer [N];

  logic          take;
  logic          keep;
  logic          close;
  logic          done;
  logic [N-1:0]  mask_nxt;
  logic [CW-1:0] kcnt_nxt;
  logic [CW-1:0] rd_nxt;

  always_comb begin
    take     = (state == FILL) && in_valid;
    keep     = take && !in_prune;
    close    = take && ((pos == CW'(N - 1)) || in_last);
    mask_nxt = mask;
    if (keep) mask_nxt[pos[IW-1:0]] = 1'b1;
    kcnt_nxt = keep ? kcnt + 1'b1 : kcnt;
    rd_nxt   = rd + 1'b1;
    done     = out_ready && (((state == HDR) && (kcnt == '0)) ||
                             ((state == DATA) && (rd == kcnt - 1'b1)));
  end

  always_ff @(posedge clk) begin
    if (keep) buffer[kcnt[IW-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      pos       <= '0;
      kcnt      <= '0;
      rd        <= '0;
      mask      <= '0;
      last_flag <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_hdr   <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      unique case (state)
        FILL: begin
          if (take) begin
            pos  <= pos + 1'b1;
            mask <= mask_nxt;
            kcnt <= kcnt_nxt;
            if (close) begin
              last_flag <= in_last;
              state     <= HDR;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_hdr   <= 1'b1;
              out_data  <= W'(mask_nxt);
              out_last  <= in_last && (kcnt_nxt == '0);
            end
          end
        end
        HDR: begin
          if (out_ready && (kcnt != '0)) begin
            state    <= DATA;
            rd       <= '0;
            out_hdr  <= 1'b0;
            out_data <= buffer[0];
            out_last <= last_flag && (kcnt == CW'(1));
          end
        end
        DATA: begin
          if (out_ready && (rd != kcnt - 1'b1)) begin
            rd       <= rd_nxt;
            out_data <= buffer[rd_nxt[IW-1:0]];
            out_last <= last_flag && (rd_nxt == kcnt - 1'b1);
          end
        end
        default: state <= FILL;
      endcase
      // Group-retire shared by the header-only and final-data-beat exits; overrides the case above.
      if (done) begin
        state     <= FILL;
        pos       <= '0;
        kcnt      <= '0;
        rd        <= '0;
        mask      <= '0;
        last_flag <= 1'b0;
        in_ready  <= 1'b1;
        out_valid <= 1'b0;
        out_hdr   <= 1'b0;
        out_last  <= 1'b0;
        out_data  <= '0;
      end
    end
  end

`ifdef SPARSE_PACK_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      prune_cnt <= '0;
    end else if (take && in_prune && (prune_cnt != '1)) begin
      prune_cnt <= prune_cnt + 1'b1;
    end
  end
`else
  assign prune_cnt = '0;
`endif

endmodule

// File: tb/tb_sparse_pack.sv
// Scoreboard bench for sparse_pack: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_sparse_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_prune;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_hdr;
  logic        out_last;
  logic [15:0] prune_cnt;

  int tests  = 0;
  int errors = 0;

  logic [9:0] q [$];
  logic       toggle_mode = 1'b0;
  logic       held = 1'b0;
  logic [9:0] held_beat = '0;

  sparse_pack #(.W(8), .N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_prune  (in_prune),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_hdr   (out_hdr),
    .out_last  (out_last),
    .prune_cnt (prune_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = toggle_mode ? ~out_ready : 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push(input logic hdr, input logic last, input logic [7:0] data);
    q.push_back({hdr, last, data});
  endfunction

  // Beat scoreboard, stall-stability and backpressure checks.
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held)
        check("stall_hold", {out_valid, out_hdr, out_last, out_data}, {1'b1, held_beat});
      if (out_valid)
        check("in_ready_low", in_ready, 1'b0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", {out_hdr, out_last, out_data});
        end else begin
          check("beat", {out_hdr, out_last, out_data}, q.pop_front());
        end
      end
      held      = out_valid && !out_ready;
      held_beat = {out_hdr, out_last, out_data};
    end
  end

  task automatic send(input logic [7:0] d, input logic p, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_prune = p;
    in_last  = l;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (n >= 300) check("idle_timeout", 32'(n), 32'd0);
    #1;
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_prune = 1'b0;
    in_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_hdr",   out_hdr,   1'b0);
    check("rst_out_last",  out_last,  1'b0);
    check("rst_out_data",  out_data,  8'h00);
    check("rst_prune_cnt", prune_cnt, 16'h0);

    // Full group, alternating prune.
    push(1, 0, 8'h55); push(0, 0, 8'd1); push(0, 0, 8'd3); push(0, 0, 8'd5); push(0, 0, 8'd7);
    for (int i = 1; i <= 8; i++) send(8'(i), (i % 2) == 0, 1'b0);
    check("t1_hdr_latency", {out_valid, out_hdr, out_data}, {1'b1, 1'b1, 8'h55});
    wait_idle();

    // Partial group closed by in_last.
    push(1, 0, 8'h07); push(0, 0, 8'h10); push(0, 0, 8'h20); push(0, 1, 8'h30);
    send(8'h10, 0, 0); send(8'h20, 0, 0); send(8'h30, 0, 1);
    wait_idle();

    // All pruned, final group of the tensor.
    push(1, 1, 8'h00);
    for (int i = 0; i < 8; i++) send(8'hEE, 1'b1, i == 7);
    check("t3_hdr_valid", {out_valid, out_hdr, out_last}, 3'b111);
    @(posedge clk);
    #1;
    check("t3_ready_back", {in_ready, out_valid}, 2'b10);
    wait_idle();

    // Backpressure with out_ready toggling.
    toggle_mode = 1'b1;
    push(1, 0, 8'hB6); push(0, 0, 8'hA1); push(0, 0, 8'hA2); push(0, 0, 8'hA4);
    push(0, 0, 8'hA5); push(0, 0, 8'hA7);
    for (int i = 0; i < 8; i++) send(8'hA0 + 8'(i), (i == 0) || (i == 3) || (i == 6), 1'b0);
    wait_idle();
    toggle_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset after two of five kept data beats.
    push(1, 0, 8'h1F); push(0, 0, 8'hB0); push(0, 0, 8'hB1);
    for (int i = 0; i < 8; i++) send(8'hB0 + 8'(i), i >= 5, 1'b0);
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (n >= 300) check("rst_wait_timeout", 32'(n), 32'd0);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_state", {out_valid, in_ready}, 2'b01);
    rst = 1'b0;
    push(1, 0, 8'h03); push(0, 0, 8'h41); push(0, 1, 8'h42);
    send(8'h41, 0, 0); send(8'h42, 0, 1);
    wait_idle();

    // 32 elements, 20 pruned; in_last on the final position of a full group.
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 8; i++) begin
        if (i == 0) push(1, 0, 8'h15);
        if (i == 0 || i == 2 || i == 4) push(0, (g == 3) && (i == 4), 8'h60 + 8'(g * 8 + i));
        send(8'h60 + 8'(g * 8 + i), !(i == 0 || i == 2 || i == 4), (g == 3) && (i == 7));
      end
    end
    wait_idle();
`ifdef SPARSE_PACK_STAT_EN
    check("prune_cnt", prune_cnt, 16'd20);
`else
    check("prune_cnt", prune_cnt, 16'd0);
`endif
    check("final_idle", {in_ready, out_valid, 8'(q.size())}, {1'b1, 1'b0, 8'd0});

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
